// File: rtl/logic_op_explorer_pkg.sv
// Shared types and the combinational operation table for logic_op_explorer.
package logic_op_explorer_pkg;

    localparam int unsigned MAX_WIDTH = 16;

    typedef enum logic [3:0] {
        OP_AND      = 4'd0,
        OP_OR       = 4'd1,
        OP_NOT_A    = 4'd2,
        OP_XOR      = 4'd3,
        OP_XOR_EXP  = 4'd4,
        OP_XOR_ONES = 4'd5,
        OP_NAND     = 4'd6,
        OP_NAND_DM  = 4'd7,
        OP_NOR      = 4'd8,
        OP_NOR_DM   = 4'd9
    } op_t;

    localparam logic [3:0] OP_FIRST = 4'd0;
    localparam logic [3:0] OP_LAST  = 4'd9;

    // Evaluate at full width; callers keep the low WIDTH bits.
    function automatic logic [MAX_WIDTH-1:0] apply_op(input op_t op,
                                                      input logic [MAX_WIDTH-1:0] a,
                                                      input logic [MAX_WIDTH-1:0] b);
        logic [MAX_WIDTH-1:0] r;
        case (op)
            OP_AND:      r = a & b;
            OP_OR:       r = a | b;
            OP_NOT_A:    r = ~a;
            OP_XOR:      r = a ^ b;
            OP_XOR_EXP:  r = (a | b) & ~(a & b);
            OP_XOR_ONES: r = a ^ {MAX_WIDTH{1'b1}};
            OP_NAND:     r = ~(a & b);
            OP_NAND_DM:  r = ~a | ~b;
            OP_NOR:      r = ~(a | b);
            OP_NOR_DM:   r = ~a & ~b;
            default:     r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_op_explorer_button_debouncer.sv
// Button synchroniser + debouncer: 2-flop sync, stable-count filter, rise pulse.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_meta;
    logic             btn_sync;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
        end else begin
            btn_rise <= 1'b0;
            if (btn_sync == btn_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt       <= '0;
                btn_level <= btn_sync;
                btn_rise  <= btn_sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/logic_op_explorer.sv
// Logic operation demonstrator: buttons step op_sel, LEDs show f(op_sel, A, B).
// Optional feature macro: LOGIC_OP_EXPLORER_AUTO_STEP_EN (periodic auto-advance).
module logic_op_explorer
    import logic_op_explorer_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned AUTO_PERIOD     = 100000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_a,
    input  logic [WIDTH-1:0] sw_b,
    input  logic             btn_next,
    input  logic             btn_prev,
    output logic [WIDTH-1:0] led,
    output logic [3:0]       op_sel
);

    logic [WIDTH-1:0] a_meta;
    logic [WIDTH-1:0] a_sync;
    logic [WIDTH-1:0] b_meta;
    logic [WIDTH-1:0] b_sync;
    logic             next_rise;
    logic             prev_rise;
    logic             auto_pulse_c;
    logic             step_next_c;
    logic             step_prev_c;
    logic [3:0]       op_next_c;

    // Switch synchronisers; switches are not debounced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_meta <= '0;
            a_sync <= '0;
            b_meta <= '0;
            b_sync <= '0;
        end else begin
            a_meta <= sw_a;
            a_sync <= a_meta;
            b_meta <= sw_b;
            b_sync <= b_meta;
        end
    end

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw   (btn_next),
        .btn_level (),
        .btn_rise  (next_rise)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_raw   (btn_prev),
        .btn_level (),
        .btn_rise  (prev_rise)
    );

`ifdef LOGIC_OP_EXPLORER_AUTO_STEP_EN
    localparam int unsigned AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

    logic [AUTO_W-1:0] auto_cnt;

    // Free-running step timer, restarted by any debounced button pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_cnt <= '0;
        end else if (next_rise || prev_rise || (auto_cnt == AUTO_LAST)) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + AUTO_W'(1);
        end
    end

    assign auto_pulse_c = (auto_cnt == AUTO_LAST);
`else
    assign auto_pulse_c = 1'b0;
`endif

    assign step_next_c = next_rise | auto_pulse_c;
    assign step_prev_c = prev_rise;

    // op_sel state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_sel <= OP_FIRST;
        end else begin
            op_sel <= op_next_c;
        end
    end

    // Next op: wrap in 0..9, simultaneous steps cancel, illegal codes recover to 0.
    always_comb begin
        op_next_c = op_sel;
        if (op_sel > OP_LAST) begin
            op_next_c = OP_FIRST;
        end else if (step_next_c && !step_prev_c) begin
            op_next_c = (op_sel == OP_LAST) ? OP_FIRST : op_sel + 4'd1;
        end else if (step_prev_c && !step_next_c) begin
            op_next_c = (op_sel == OP_FIRST) ? OP_LAST : op_sel - 4'd1;
        end
    end

    // Registered result of the currently selected operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led <= '0;
        end else begin
            led <= WIDTH'(apply_op(op_t'(op_sel), MAX_WIDTH'(a_sync), MAX_WIDTH'(b_sync)));
        end
    end

endmodule

// File: tb/tb_logic_op_explorer.sv
// Self-checking bench for logic_op_explorer (WIDTH=4, DEBOUNCE_CYCLES=4, AUTO_PERIOD=20).
module tb_logic_op_explorer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] sw_a;
    logic [W-1:0] sw_b;
    logic         btn_next;
    logic         btn_prev;
    logic [W-1:0] led;
    logic [3:0]   op_sel;

    int           n_vec = 0;
    int           n_err = 0;
    int           exp_op = 0;
    logic [W-1:0] cur_a = '0;
    logic [W-1:0] cur_b = '0;

    always #5 clk = ~clk;

    logic_op_explorer #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .AUTO_PERIOD(20)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw_a     (sw_a),
        .sw_b     (sw_b),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .led      (led),
        .op_sel   (op_sel)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Truth table per op, indexed by {a_bit, b_bit}, applied bit by bit.
    function automatic logic [W-1:0] ref_led(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [3:0]   tt;
        logic [W-1:0] r;
        case (op)
            0: tt = 4'b1000;
            1: tt = 4'b1110;
            2: tt = 4'b0011;
            3: tt = 4'b0110;
            4: tt = 4'b0110;
            5: tt = 4'b0011;
            6: tt = 4'b0111;
            7: tt = 4'b0111;
            8: tt = 4'b0001;
            9: tt = 4'b0001;
            default: tt = 4'b0000;
        endcase
        for (int i = 0; i < int'(W); i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Clean press of either/both buttons; checks step timing and the new result.
    task automatic press(input bit nxt, input bit prv, input string tag);
        btn_next = nxt;
        btn_prev = prv;
        tick(6);
        check({tag, "_op_before"}, 32'(op_sel), 32'(exp_op));
        if (nxt && !prv) exp_op = (exp_op + 1) % 10;
        if (prv && !nxt) exp_op = (exp_op + 9) % 10;
        tick(1);
        check({tag, "_op_after"}, 32'(op_sel), 32'(exp_op));
        tick(1);
        check({tag, "_led"}, 32'(led), 32'(ref_led(exp_op, cur_a, cur_b)));
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(8);
    endtask

    logic [W-1:0] spec_tab [10];

    initial begin
        spec_tab = '{4'b1000, 4'b1110, 4'b0011, 4'b0110, 4'b0110,
                     4'b0011, 4'b0111, 4'b0111, 4'b0001, 4'b0001};
        reset_n  = 1'b1;
        sw_a     = '0;
        sw_b     = '0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        #1 reset_n = 1'b0;

        // Reset state, during and just after reset.
        tick(2);
        check("rst_led", 32'(led), 32'(0));
        check("rst_op", 32'(op_sel), 32'(0));
        reset_n = 1'b1;
        tick(1);
        check("rel_led", 32'(led), 32'(0));
        check("rel_op", 32'(op_sel), 32'(0));

        // Switch latency and the full op table with A=1100, B=1010.
        sw_a = 4'b1100;
        sw_b = 4'b1010;
        cur_a = sw_a;
        cur_b = sw_b;
        tick(2);
        check("sw_lat2", 32'(led), 32'(0));
        tick(1);
        check("sw_lat3", 32'(led), 32'(spec_tab[0]));
        for (int k = 1; k <= 10; k++) begin
            press(1'b1, 1'b0, "walk");
            check("walk_tab", 32'(led), 32'(spec_tab[exp_op]));
        end

        // Bouncing next button: one step only, after stable high.
        for (int i = 0; i < 5; i++) begin
            btn_next = ~btn_next;
            tick(2);
            check("bounce_hold", 32'(op_sel), 32'(0));
        end
        tick(4);
        check("bounce_before", 32'(op_sel), 32'(0));
        tick(1);
        exp_op = 1;
        check("bounce_after", 32'(op_sel), 32'(1));
        btn_next = 1'b0;
        tick(8);

        // Wrap boundaries.
        press(1'b0, 1'b1, "prev_1to0");
        press(1'b0, 1'b1, "prev_wrap");
        check("wrap_to9", 32'(op_sel), 32'(9));
        press(1'b1, 1'b0, "next_wrap");
        check("wrap_to0", 32'(op_sel), 32'(0));

        // Simultaneous next and prev cancel.
        press(1'b1, 1'b0, "pre_both");
        press(1'b1, 1'b0, "pre_both2");
        press(1'b1, 1'b1, "both");
        check("both_op", 32'(op_sel), 32'(2));

        // Reset mid-debounce with the button held.
        btn_next = 1'b1;
        tick(4);
        reset_n = 1'b0;
        #1;
        check("midrst_op", 32'(op_sel), 32'(0));
        check("midrst_led", 32'(led), 32'(0));
        exp_op = 0;
        tick(1);
        reset_n = 1'b1;
        tick(6);
        check("held_before", 32'(op_sel), 32'(0));
        tick(1);
        exp_op = 1;
        check("held_after", 32'(op_sel), 32'(1));
        btn_next = 1'b0;
        tick(8);

        // Randomised ops and operands against the truth-table model.
        for (int it = 0; it < 24; it++) begin
            logic [W-1:0] old_a;
            logic [W-1:0] old_b;
            int           act;
            act = int'($urandom_range(0, 3));
            case (act)
                0: press(1'b1, 1'b0, "rnd_next");
                1: press(1'b0, 1'b1, "rnd_prev");
                2: press(1'b1, 1'b1, "rnd_both");
                default: ;
            endcase
            old_a = cur_a;
            old_b = cur_b;
            cur_a = W'($urandom);
            cur_b = W'($urandom);
            sw_a = cur_a;
            sw_b = cur_b;
            tick(2);
            check("rnd_old", 32'(led), 32'(ref_led(exp_op, old_a, old_b)));
            tick(1);
            check("rnd_new", 32'(led), 32'(ref_led(exp_op, cur_a, cur_b)));
            check("rnd_op", 32'(op_sel), 32'(exp_op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
